// File: rtl/i2c_xfer_arbiter_if.sv
// i2c_xfer_arbiter_if: command/completion bus between the arbiter and the shared I2C master.
interface i2c_xfer_arbiter_if;
   logic       m_ready;
   logic [6:0] m_addr;
   logic       m_rw;
   logic [7:0] m_data_cnt;
   logic       m_done;
   modport master (output m_ready, m_addr, m_rw, m_data_cnt, input m_done);
   modport slave  (input m_ready, m_addr, m_rw, m_data_cnt, output m_done);
endinterface

// File: rtl/i2c_xfer_arbiter.sv
// i2c_xfer_arbiter: round-robin sharing of one I2C master among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the per-transfer abort timer.
module i2c_xfer_arbiter #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [7*NREQ-1:0]  req_addr,
   input  logic [NREQ-1:0]    req_rw,
   input  logic [8*NREQ-1:0]  req_cnt,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic               timeout,
   i2c_xfer_arbiter_if.master m
);
   localparam int W = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE} state_t;
   state_t       state;
   logic [W-1:0] last;
   logic [W-1:0] win;
   logic [6:0]   win_addr;
   logic         win_rw;
   logic [7:0]   win_cnt;
   logic         m_done_q;
   logic         done_rise;
   logic         to_hit;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
      $error("i2c_xfer_arbiter: parameter out of range");
   end

   assign done_rise = m.m_done & ~m_done_q;

   // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      win = last;
      for (int i = NREQ - 1; i >= 0; i--) win = req[i] ? W'(i) : win;
      for (int i = NREQ - 1; i >= 0; i--) win = (req[i] && i > int'(last)) ? W'(i) : win;
      win_addr = '0;
      win_rw   = 1'b0;
      win_cnt  = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_addr = (W'(i) == win) ? req_addr[7*i +: 7] : win_addr;
         win_rw   = (W'(i) == win) ? req_rw[i] : win_rw;
         win_cnt  = (W'(i) == win) ? req_cnt[8*i +: 8] : win_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last         <= W'(NREQ - 1);
         gnt          <= '0;
         done         <= '0;
         busy         <= 1'b0;
         m_done_q     <= 1'b0;
         m.m_ready    <= 1'b0;
         m.m_addr     <= '0;
         m.m_rw       <= 1'b0;
         m.m_data_cnt <= '0;
      end else begin
         m_done_q <= m.m_done;
         done     <= '0;
         case (state)
            IDLE: if (|req) begin
               gnt          <= NREQ'(1) << win;
               last         <= win;
               m.m_addr     <= win_addr;
               m.m_rw       <= win_rw;
               m.m_data_cnt <= win_cnt;
               m.m_ready    <= 1'b1;
               busy         <= 1'b1;
               state        <= WAIT_DONE;
            end
            // Drop m_ready on the completion edge so the master, still in STOP, does not restart.
            WAIT_DONE: if (done_rise || to_hit) begin
               m.m_ready <= 1'b0;
               done      <= gnt;
               gnt       <= '0;
               state     <= RELEASE;
            end
            RELEASE: if (!m.m_done) begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0] cyc;
   assign to_hit = cyc == 16'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc     <= '0;
         timeout <= 1'b0;
      end else begin
         cyc     <= (state == WAIT_DONE) ? cyc + 16'd1 : '0;
         timeout <= (state == WAIT_DONE) && to_hit && !done_rise;
      end
   end
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// tb_i2c_xfer_arbiter: directed checks of grant order, completion handshake and reset behaviour.
module tb_i2c_xfer_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [27:0] req_addr = {7'h33, 7'h22, 7'h50, 7'h11};
   logic [3:0]  req_rw = 4'b1100;
   logic [31:0] req_cnt = {8'd7, 8'd5, 8'd2, 8'd9};
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic        timeout;
   logic [6:0]  exp_addr [4] = '{7'h11, 7'h50, 7'h22, 7'h33};
   int          checks = 0;
   int          errors = 0;

   i2c_xfer_arbiter_if bus();

   i2c_xfer_arbiter #(.NREQ(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_cnt(req_cnt), .gnt(gnt), .done(done), .busy(busy), .timeout(timeout), .m(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic pulse_reset;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Waits for a grant, completes it with a short m_done level, waits for busy to fall.
   task automatic run_one(output logic [3:0] g, output logic [3:0] d, output logic [6:0] a);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready !== 1'b1 && n < 20);
      checks++;
      if (bus.m_ready !== 1'b1) begin errors++; $display("FAIL grant_wait m_ready=%b after %0d cycles, want 1", bus.m_ready, n); end
      g = gnt;
      a = bus.m_addr;
      bus.m_done = 1'b1;
      @(negedge clk);
      d = done;
      repeat (2) @(negedge clk);
      bus.m_done = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 20);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL release_wait busy=%b after %0d cycles, want 0", busy, n); end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req = '0;
      bus.m_done = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (gnt !== 4'b0 || done !== 4'b0) begin errors++; $display("FAIL reset_gnt_done gnt=%b done=%b, want 0000 0000", gnt, done); end
      checks++;
      if ({busy, timeout, bus.m_ready} !== 3'b0) begin errors++; $display("FAIL reset_flags busy/timeout/m_ready=%b, want 000", {busy, timeout, bus.m_ready}); end
      checks++;
      if ({bus.m_addr, bus.m_rw, bus.m_data_cnt} !== 16'h0) begin errors++; $display("FAIL reset_mfields got %h, want 0000", {bus.m_addr, bus.m_rw, bus.m_data_cnt}); end
      rst = 1'b1;
   endtask

   task automatic test_single;
      int bad;
      @(negedge clk);
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || bus.m_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_grant gnt=%b m_ready=%b busy=%b, want 0010 1 1", gnt, bus.m_ready, busy); end
      checks++;
      if (bus.m_addr !== 7'h50 || bus.m_data_cnt !== 8'd2 || bus.m_rw !== 1'b0) begin errors++; $display("FAIL single_fields addr=%h cnt=%0d rw=%b, want 50 2 0", bus.m_addr, bus.m_data_cnt, bus.m_rw); end
      req = '0;
      bus.m_done = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 4'b0010 || bus.m_ready !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL single_done done=%b m_ready=%b gnt=%b busy=%b timeout=%b, want 0010 0 0000 1 0", done, bus.m_ready, gnt, busy, timeout); end
      bad = 0;
      repeat (48) begin
         @(negedge clk);
         if (done !== 4'b0 || busy !== 1'b1 || bus.m_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_hold %0d bad cycles while m_done high, want 0", bad); end
      bus.m_done = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.m_addr !== 7'h50) begin errors++; $display("FAIL single_release busy=%b addr=%h, want 0 50", busy, bus.m_addr); end
   endtask

   task automatic test_contention;
      logic [3:0] g, d;
      logic [6:0] a;
      pulse_reset();
      req = 4'b1001;
      run_one(g, d, a);
      checks++;
      if (g !== 4'b0001 || d !== 4'b0001) begin errors++; $display("FAIL contention_first gnt=%b done=%b, want 0001 0001", g, d); end
      run_one(g, d, a);
      req = '0;
      checks++;
      if (g !== 4'b1000 || d !== 4'b1000 || a !== 7'h33) begin errors++; $display("FAIL contention_second gnt=%b done=%b addr=%h, want 1000 1000 33", g, d, a); end
   endtask

   task automatic test_fairness;
      logic [3:0] g, d, eg;
      logic [6:0] a;
      pulse_reset();
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         run_one(g, d, a);
         eg = 4'b0001 << (i % 4);
         checks++;
         if (g !== eg || d !== eg || a !== exp_addr[i % 4]) begin errors++; $display("FAIL fairness_%0d gnt=%b done=%b addr=%h, want %b %b %h", i, g, d, a, eg, eg, exp_addr[i % 4]); end
      end
      req = '0;
   endtask

   task automatic test_req_drop;
      int n, bad;
      pulse_reset();
      req = 4'b0001;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready !== 1'b1 && n < 20);
      req = '0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.m_addr !== 7'h11 || bus.m_ready !== 1'b1 || gnt !== 4'b0001) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL drop_hold %0d bad cycles after req drop, want 0", bad); end
      bus.m_done = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 4'b0001 || bus.m_addr !== 7'h11) begin errors++; $display("FAIL drop_done done=%b addr=%h, want 0001 11", done, bus.m_addr); end
      bus.m_done = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.m_addr !== 7'h11) begin errors++; $display("FAIL drop_release busy=%b addr=%h, want 0 11", busy, bus.m_addr); end
   endtask

   task automatic test_reset_mid;
      logic [3:0] g, d;
      logic [6:0] a;
      int n;
      req = 4'b0010;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready !== 1'b1 && n < 20);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.m_ready !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL midreset_async m_ready=%b gnt=%b busy=%b done=%b, want 0 0000 0 0000", bus.m_ready, gnt, busy, done); end
      bus.m_done = 1'b1;
      @(negedge clk);
      bus.m_done = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 4'b0 || gnt !== 4'b0) begin errors++; $display("FAIL midreset_nodone done=%b gnt=%b, want 0000 0000", done, gnt); end
      req = 4'b0110;
      rst = 1'b1;
      run_one(g, d, a);
      checks++;
      if (g !== 4'b0010) begin errors++; $display("FAIL midreset_pointer gnt=%b, want 0010", g); end
      req = 4'b0100;
      run_one(g, d, a);
      req = '0;
      checks++;
      if (g !== 4'b0100 || d !== 4'b0100 || a !== 7'h22) begin errors++; $display("FAIL midreset_req2 gnt=%b done=%b addr=%h, want 0100 0100 22", g, d, a); end
   endtask

   task automatic test_stale_done;
      int bad;
      @(negedge clk);
      bus.m_done = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 4'b0 || busy !== 1'b0 || bus.m_ready !== 1'b0) begin errors++; $display("FAIL stale_idle done=%b busy=%b m_ready=%b, want 0000 0 0", done, busy, bus.m_ready); end
      req = 4'b1000;
      @(negedge clk);
      req = '0;
      checks++;
      if (gnt !== 4'b1000 || bus.m_ready !== 1'b1 || bus.m_rw !== 1'b1 || bus.m_data_cnt !== 8'd7) begin errors++; $display("FAIL stale_grant gnt=%b m_ready=%b rw=%b cnt=%0d, want 1000 1 1 7", gnt, bus.m_ready, bus.m_rw, bus.m_data_cnt); end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 4'b0 || bus.m_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stale_level %0d cycles completed on a held level, want 0", bad); end
      bus.m_done = 1'b0;
      @(negedge clk);
      bus.m_done = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 4'b1000 || bus.m_ready !== 1'b0) begin errors++; $display("FAIL stale_rise done=%b m_ready=%b, want 1000 0", done, bus.m_ready); end
      bus.m_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [3:0] g, d;
      logic [6:0] a;
      req = 4'b0100;
      run_one(g, d, a);
      checks++;
      if (g !== 4'b0100 || d !== 4'b0100) begin errors++; $display("FAIL b2b_first gnt=%b done=%b, want 0100 0100", g, d); end
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || bus.m_ready !== 1'b1) begin errors++; $display("FAIL b2b_regrant gnt=%b m_ready=%b one cycle after busy fell, want 0100 1", gnt, bus.m_ready); end
      bus.m_done = 1'b1;
      @(negedge clk);
      req = '0;
      checks++;
      if (done !== 4'b0100) begin errors++; $display("FAIL b2b_second done=%b, want 0100", done); end
      bus.m_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

`ifdef I2C_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      pulse_reset();
      req = 4'b0001;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready !== 1'b1 && n < 20);
      repeat (99) @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || bus.m_ready !== 1'b1) begin errors++; $display("FAIL timeout_early timeout=%b m_ready=%b at cycle 99, want 0 1", timeout, bus.m_ready); end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b1 || done !== 4'b0001 || bus.m_ready !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL timeout_fire timeout=%b done=%b m_ready=%b gnt=%b, want 1 0001 0 0000", timeout, done, bus.m_ready, gnt); end
      req = '0;
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || done !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_after timeout=%b done=%b busy=%b, want 0 0000 0", timeout, done, busy); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_req_drop();
      test_reset_mid();
      test_stale_done();
      test_back_to_back();
`ifdef I2C_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
